// File: rtl/run_ctrl_if.sv
// Data-memory port shared between run_ctrl (master) and the memory/CPU side (slave).
interface run_ctrl_if;
  logic       mem_own;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;

  modport master (output mem_own, mem_addr, mem_wdata, mem_we, input mem_rdata);
  modport slave  (input mem_own, mem_addr, mem_wdata, mem_we, output mem_rdata);
endinterface

// File: rtl/run_ctrl.sv
// Run sequencer: clears and loads data memory, releases the CPU until halt or
// timeout, then reads the 32-bit result back from mem[5..8].
//   state | meaning
//   IDLE  | waiting for go, CPU held
//   CLEAR | zero data memory, one word per cycle
//   LOAD  | write operand bytes to mem[1..4]
//   RUN   | CPU owns memory and runs, cycles counted
//   READ  | shift mem[5..8] into result
//   DONE  | run finished, results held until next go
module run_ctrl #(
  parameter logic [15:0] TIMEOUT   = 16'd1000,
  parameter int          CLR_DEPTH = 256
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        go,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  run_ctrl_if.master  mem,
  output logic        start,
  input  logic        halt,
  output logic [31:0] result,
  output logic [15:0] cycles,
  output logic        busy,
  output logic        done,
  output logic        timeout
);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, READ, DONE} state_t;

  localparam logic [15:0] CLR_LAST = 16'(CLR_DEPTH - 1);

  state_t      state_q, state_d;
  logic [15:0] tmr_q, tmr_d;
  logic [15:0] op_a_q, op_b_q;
  logic        accept, run_inc, rd_shift, to_set;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    accept   = 1'b0;
    run_inc  = 1'b0;
    rd_shift = 1'b0;
    to_set   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (go) begin
          state_d = CLEAR;
          tmr_d   = CLR_LAST;
          accept  = 1'b1;
        end
      end
      CLEAR: begin
        if (tmr_q == 16'd0) begin
          state_d = LOAD;
          tmr_d   = 16'd3;
        end else begin
          tmr_d = tmr_q - 16'd1;
        end
      end
      LOAD: begin
        if (tmr_q == 16'd0) state_d = RUN;
        else                tmr_d   = tmr_q - 16'd1;
      end
      RUN: begin
        // halt takes priority over the timeout terminal count
        if (halt) begin
          state_d = READ;
          tmr_d   = 16'd3;
        end else if (cycles == TIMEOUT - 16'd1) begin
          state_d = DONE;
          to_set  = 1'b1;
        end else begin
          run_inc = 1'b1;
        end
      end
      READ: begin
        rd_shift = 1'b1;
        if (tmr_q == 16'd0) state_d = DONE;
        else                tmr_d   = tmr_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      tmr_q   <= 16'd0;
      op_a_q  <= 16'd0;
      op_b_q  <= 16'd0;
      result  <= 32'd0;
      cycles  <= 16'd0;
      timeout <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      if (accept) begin
        op_a_q  <= op_a;
        op_b_q  <= op_b;
        result  <= 32'd0;
        cycles  <= 16'd0;
        timeout <= 1'b0;
      end
      if (run_inc && cycles != 16'hFFFF) cycles <= cycles + 16'd1;
      if (rd_shift) result <= {result[23:0], mem.mem_rdata};
      if (to_set) timeout <= 1'b1;
    end
  end

  // Addresses are derived from the down-counter so no separate address register is needed.
  always_comb begin
    mem.mem_own   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = 8'd0;
    mem.mem_wdata = 8'd0;
    case (state_q)
      CLEAR: begin
        mem.mem_own  = 1'b1;
        mem.mem_we   = 1'b1;
        mem.mem_addr = CLR_LAST[7:0] - tmr_q[7:0];
      end
      LOAD: begin
        mem.mem_own  = 1'b1;
        mem.mem_we   = 1'b1;
        mem.mem_addr = 8'd4 - tmr_q[7:0];
        case (tmr_q[1:0])
          2'd3:    mem.mem_wdata = op_a_q[15:8];
          2'd2:    mem.mem_wdata = op_a_q[7:0];
          2'd1:    mem.mem_wdata = op_b_q[15:8];
          default: mem.mem_wdata = op_b_q[7:0];
        endcase
      end
      READ: begin
        mem.mem_own  = 1'b1;
        mem.mem_addr = 8'd8 - tmr_q[7:0];
      end
      default: ;
    endcase
  end

  assign start = (state_q != RUN);
  assign busy  = (state_q != IDLE) && (state_q != DONE);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: memory + CPU model, vector table, scoreboard queue.
module tb_run_ctrl;
  localparam logic [15:0] TO = 16'd50;
  localparam int          CD = 256;

  logic        CLK = 1'b0;
  logic        reset_n = 1'b1;
  logic        go = 1'b0;
  logic [15:0] op_a = 16'd0, op_b = 16'd0;
  logic        start, halt = 1'b0;
  logic [31:0] result;
  logic [15:0] cycles;
  logic        busy, done, timeout;

  run_ctrl_if bus ();

  run_ctrl #(.TIMEOUT(TO), .CLR_DEPTH(CD)) dut (
    .CLK(CLK), .reset_n(reset_n), .go(go), .op_a(op_a), .op_b(op_b),
    .mem(bus), .start(start), .halt(halt), .result(result), .cycles(cycles),
    .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  logic [7:0] mem [0:255];
  assign bus.mem_rdata = mem[bus.mem_addr];

  // CPU/memory model state, written only by the monitor
  int run_k = 0, wr_idx = 0;
  int clr_bad = 0, own_bad = 0, start_bad = 0, load_bad = 0, mem_bad = 0;
  // CPU program, written only by the main sequence
  logic [15:0] halt_after = 16'd0;
  logic        pre_halt = 1'b0;
  logic [31:0] cpu_out = 32'd0;

  always @(negedge CLK) begin : monitor
    logic [7:0]  ea, ed;
    logic [31:0] opw;
    int          k;
    if (reset_n && !busy && go) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'hAA;
      wr_idx = 0;
    end
    if (!bus.mem_own && (bus.mem_we || bus.mem_addr != 8'd0 || bus.mem_wdata != 8'd0)) own_bad++;
    if (bus.mem_we) begin
      if (!bus.mem_own || !start) start_bad++;
      opw = {op_a, op_b};
      if (wr_idx < CD) begin
        ea = 8'(wr_idx);
        ed = 8'd0;
      end else begin
        k  = wr_idx - CD;
        ea = 8'(k + 1);
        ed = (k <= 3) ? opw[8*(3-k) +: 8] : 8'h00;
        if (k > 3) clr_bad++;
      end
      if (bus.mem_addr != ea || bus.mem_wdata != ed) clr_bad++;
      mem[bus.mem_addr] = bus.mem_wdata;
      wr_idx++;
    end
    if (busy && !start) begin
      run_k++;
      if (run_k == 1) begin
        if ({mem[1], mem[2], mem[3], mem[4]} != {op_a, op_b}) load_bad++;
        for (int i = 0; i < 256; i++)
          if ((i == 0 || i > 4) && mem[i] != 8'h00) mem_bad++;
        {mem[5], mem[6], mem[7], mem[8]} = cpu_out;
      end
      halt = (run_k > int'(halt_after));
    end else begin
      run_k = 0;
      halt  = pre_halt;
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_start"},   32'(start), 32'd1);
    chk({tag, "_own"},     32'(bus.mem_own), 32'd0);
    chk({tag, "_we"},      32'(bus.mem_we), 32'd0);
    chk({tag, "_addr"},    32'(bus.mem_addr), 32'd0);
    chk({tag, "_wdata"},   32'(bus.mem_wdata), 32'd0);
    chk({tag, "_result"},  result, 32'd0);
    chk({tag, "_cycles"},  32'(cycles), 32'd0);
    chk({tag, "_busy"},    32'(busy), 32'd0);
    chk({tag, "_done"},    32'(done), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  typedef struct {
    logic [15:0] a, b, ha;
    logic        ph;
    logic [31:0] cpu;
    logic [31:0] e_res;
    logic [15:0] e_cyc;
    logic        e_to;
    int          e_lat;
  } vec_t;

  vec_t vecs[6];
  vec_t sb[$];

  task automatic chk_side(input string tag);
    chk({tag, "_wr_count"},  32'(wr_idx), 32'(CD + 4));
    chk({tag, "_clr_order"}, 32'(clr_bad), 32'd0);
    chk({tag, "_bus_idle"},  32'(own_bad), 32'd0);
    chk({tag, "_we_start"},  32'(start_bad), 32'd0);
    chk({tag, "_load"},      32'(load_bad), 32'd0);
    chk({tag, "_cleared"},   32'(mem_bad), 32'd0);
  endtask

  task automatic chk_result(input string tag, input vec_t e);
    chk({tag, "_result"},  result, e.e_res);
    chk({tag, "_cycles"},  32'(cycles), 32'(e.e_cyc));
    chk({tag, "_timeout"}, 32'(timeout), 32'(e.e_to));
    chk({tag, "_start"},   32'(start), 32'd1);
    chk({tag, "_busy"},    32'(busy), 32'd0);
  endtask

  task automatic run_one(input vec_t v, input string tag);
    vec_t e;
    int   lat;
    bit   got;
    @(posedge CLK); #1;
    op_a = v.a; op_b = v.b; halt_after = v.ha; pre_halt = v.ph; cpu_out = v.cpu;
    go = 1'b1;
    sb.push_back(v);
    @(posedge CLK); #1;
    go = 1'b0;
    lat = 0; got = 1'b0;
    for (int c = 0; c < 2000 && !got; c++) begin
      @(posedge CLK); #1;
      lat++;
      if (done) got = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    e = sb.pop_front();
    chk({tag, "_latency"}, 32'(lat), 32'(e.e_lat));
    chk_result(tag, e);
    chk_side(tag);
    pre_halt = 1'b0;
  endtask

  initial begin
    vec_t v1, v2;
    int   low;
    bit   got;
    // a, b, halt_after, pre_halt, cpu_out, exp result, exp cycles, exp timeout, exp latency
    vecs[0] = '{16'h03FF, 16'hFFFB, 16'd20,   1'b0, 32'h0403FFFA, 32'h0403FFFA, 16'd20, 1'b0, CD + 20 + 9};
    vecs[1] = '{16'hA55A, 16'h0F0F, 16'd0,    1'b0, 32'h11223344, 32'h11223344, 16'd0,  1'b0, CD + 0 + 9};
    vecs[2] = '{16'h8001, 16'h7FFE, 16'd5,    1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 16'd5,  1'b0, CD + 5 + 9};
    vecs[3] = '{16'h1234, 16'h5678, 16'hFFFF, 1'b0, 32'hDEADBEEF, 32'h00000000, 16'd49, 1'b1, CD + 4 + 50};
    vecs[4] = '{16'h0001, 16'h0002, 16'd48,   1'b0, 32'h89ABCDEF, 32'h89ABCDEF, 16'd48, 1'b0, CD + 48 + 9};
    vecs[5] = '{16'hFEDC, 16'hBA98, 16'd49,   1'b0, 32'h76543210, 32'h76543210, 16'd49, 1'b0, CD + 49 + 9};

    #2 reset_n = 1'b0;
    #20 chk_reset("reset");
    @(negedge CLK) reset_n = 1'b1;
    repeat (3) @(posedge CLK);
    #1 chk("idle_no_go_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++) run_one(vecs[i], $sformatf("vec%0d", i));

    // reset during the 10th RUN cycle
    @(posedge CLK); #1;
    op_a = 16'h4321; op_b = 16'h8765; halt_after = 16'd30; cpu_out = 32'h01010101;
    go = 1'b1;
    @(posedge CLK); #1;
    go = 1'b0;
    for (int c = 0; c < 600 && run_k != 10; c++) begin
      @(negedge CLK); #1;
    end
    chk("midrun_reached", 32'(run_k), 32'd10);
    reset_n = 1'b0;
    #1 chk_reset("midrun_reset");
    @(negedge CLK) reset_n = 1'b1;
    repeat (5) @(posedge CLK);
    #1 chk("post_reset_idle", 32'(busy), 32'd0);
    run_one(vecs[0], "after_reset");

    // go held high: two back-to-back runs
    v1 = '{16'h1111, 16'h2222, 16'd3, 1'b0, 32'h01020304, 32'h01020304, 16'd3, 1'b0, CD + 3 + 9};
    v2 = '{16'h3333, 16'h4444, 16'd7, 1'b0, 32'h05060708, 32'h05060708, 16'd7, 1'b0, CD + 7 + 9};
    @(posedge CLK); #1;
    op_a = v1.a; op_b = v1.b; halt_after = v1.ha; cpu_out = v1.cpu;
    go = 1'b1;
    sb.push_back(v1);
    got = 1'b0;
    for (int c = 0; c < 2000 && !got; c++) begin
      @(posedge CLK); #1;
      if (done) got = 1'b1;
    end
    chk("b2b1_done_seen", 32'(got), 32'd1);
    chk_result("b2b1", sb.pop_front());
    chk_side("b2b1");
    op_a = v2.a; op_b = v2.b; halt_after = v2.ha; cpu_out = v2.cpu;
    sb.push_back(v2);
    low = 0; got = 1'b0;
    for (int c = 0; c < 2000 && !got; c++) begin
      @(posedge CLK); #1;
      if (done) got = 1'b1;
      else      low++;
    end
    go = 1'b0;
    chk("b2b2_done_seen", 32'(got), 32'd1);
    chk("b2b_done_low_span", 32'(low), 32'(CD + 4 + 8 + 4));
    chk_result("b2b2", sb.pop_front());
    chk_side("b2b2");
    @(posedge CLK); #1;
    chk("b2b_stop_done", 32'(done), 32'd1);
    chk("b2b_stop_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
